regfile_sb: RTL

Parametrised register file for the pipelined RV32I core, and the successor to the single-write-port register file. It provides two asynchronous read ports and two synchronous write-back ports (wb0, wb1). A per-register busy scoreboard is set at instruction issue and cleared at write-back, so the decode stage can detect RAW hazards. A live count of busy registers is exported for stall/drain logic.

---
 rtl/regfile_sb.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with busy scoreboard and busy count.
// Ports: CLK/RST, rs1/rs2 read (data+busy), issue, wb0/wb1, flush, busy_cnt.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-back forwarding).
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG),
  localparam int CW = $clog2(NREG+1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_vld,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb0_vld,
  input  logic [AW-1:0]   wb0_rd,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_vld,
  input  logic [AW-1:0]   wb1_rd,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            flush,
  output logic [CW-1:0]   busy_cnt
);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      regs_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wb1_vld && wb1_rd == AW'(i))
          regs_q[i] <= wb1_data;
        else if (wb0_vld && wb0_rd == AW'(i))
          regs_q[i] <= wb0_data;
      end
    end
  end

  // Issue is applied after the clears so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb0_vld) busy_d[wb0_rd] = 1'b0;
      if (wb1_vld) busy_d[wb1_rd] = 1'b0;
      if (issue_vld) busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++)
      cnt_d = cnt_d + CW'(busy_d[i]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (rs1_addr != '0) begin
      if (wb0_vld && wb0_rd == rs1_addr) begin
        rs1_data = wb0_data;
        rs1_busy = issue_vld && issue_rd == rs1_addr;
      end
      if (wb1_vld && wb1_rd == rs1_addr) begin
        rs1_data = wb1_data;
        rs1_busy = issue_vld && issue_rd == rs1_addr;
      end
    end
    if (rs2_addr != '0) begin
      if (wb0_vld && wb0_rd == rs2_addr) begin
        rs2_data = wb0_data;
        rs2_busy = issue_vld && issue_rd == rs2_addr;
      end
      if (wb1_vld && wb1_rd == rs2_addr) begin
        rs2_data = wb1_data;
        rs2_busy = issue_vld && issue_rd == rs2_addr;
      end
    end
    if (flush) begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule
